k052109_vram_slot_seq: RTL and testbench
========================================

K052109_VRAM_SLOT_SEQ -- requirements
Module: k052109_vram_slot_seq

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, VRAM address width; DATA_W, default 8, VRAM data width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports:
- pe  in  1  timing-generator phase E (clock/4).
- pq  in  1  timing-generator phase Q, lagging pe by one clock.
REQ-004 SHALL have CPU ports:
- cpu_req  in  1  access request.
- cpu_we  in  1  1=write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-clock completion pulse.
- cpu_rdata  out  DATA_W  CPU read data.
REQ-005 SHALL have video ports:
- vid_addr  in  ADDR_W  tile-fetch address.
- vid_data  out  DATA_W  latched tile byte.
- vid_valid  out  1  one-clock strobe when vid_data updates.
REQ-006 SHALL have VRAM ports:
- vram_addr  out  ADDR_W  VRAM address.
- vram_din  in  DATA_W  VRAM read data.
- vram_dout  out  DATA_W  VRAM write data.
- vram_oe  out  1  VRAM output enable.
- vram_we  out  1  VRAM write enable.
- sync_err  out  1  sticky phase-error flag.

Function
REQ-007 SHALL detect a slot start on a pe rising edge (pe=1, registered pe=0) and reset the phase counter to 0 on that clock.
REQ-008 SHALL advance the 2-bit phase counter every clock; phase 3 SHALL wrap to 0 only on the next slot start.
REQ-009 SHALL require a pq rising edge while phase=1; a pq rising edge at any other phase SHALL set sync_err.
REQ-010 SHALL alternate slot type with a toggle flipped on every slot start: first slot after reset = VIDEO, next = CPU, and so on.
REQ-011 SHALL use FSM states IDLE, VIDEO, CPU_RD, CPU_WR.
REQ-012 SHALL make the FSM transitions only on slot start:
- video-type slot -> VIDEO.
- CPU-type slot with captured request -> CPU_RD or CPU_WR per cpu_we.
- otherwise -> IDLE.
REQ-013 SHALL capture cpu_addr, cpu_we and cpu_wdata at the start of a CPU slot when cpu_req=1; later changes of the CPU inputs SHALL not affect the running access.
REQ-014 SHALL, in VIDEO:
- drive vram_addr=vid_addr and vram_oe=1 for phases 0-3.
- latch vram_din into vid_data at phase 3.
- pulse vid_valid on the following clock.
REQ-015 SHALL, in CPU_RD:
- drive the captured address and vram_oe=1 for phases 0-3.
- latch vram_din into cpu_rdata at phase 3.
- pulse cpu_ack on the following clock.
REQ-016 SHALL, in CPU_WR:
- drive the captured address and data.
- drive vram_we=1 in phases 1-2 only, vram_oe=0 throughout.
- pulse cpu_ack on the clock after phase 3.
REQ-017 SHALL, in IDLE, hold vram_oe=0 and vram_we=0; vram_addr SHALL hold its last value.
REQ-018 SHALL never assert vram_oe and vram_we on the same clock.
REQ-019 SHALL treat cpu_req still high on the clock after cpu_ack as a new request, served in the next CPU slot.
REQ-020 SHALL, if phase 3 passes with no new slot start, stay in phase 3 with vram_we=0 and issue no further latch or ack until the next slot start.
REQ-021 SHALL, when a slot start and cpu_ack coincide, give both their normal effect.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, return to these values on that edge, aborting any access in progress with no ack:
- FSM=IDLE, phase=0, slot toggle=VIDEO.
- vram_oe=0, vram_we=0, vram_addr=0, vram_dout=0.
- cpu_ack=0, cpu_rdata=0, vid_data=0, vid_valid=0, sync_err=0.
REQ-023 SHALL treat reset as synchronous only; no output SHALL change asynchronously.

Structure
REQ-024 SHALL take from shared package k052109_pkg:
- the slot-state enum (IDLE, VIDEO, CPU_RD, CPU_WR).
- the ADDR_W/DATA_W defaults.
- the phase constants (WE_FIRST=1, WE_LAST=2, LATCH=3).
REQ-025 SHALL put edge detection, the phase counter and sync_err in one sub-module, k052109_phase_track; the FSM and datapath stay in the top level.

Verification
REQ-026 Reset, then pe/pq quadrature clock/4 with vram_din=8'hA5 -> vid_valid pulses every 8 clocks with vid_data=8'hA5; sync_err=0.
REQ-027 cpu_req=1, cpu_we=0, cpu_addr=13'h0123 raised in a video slot, vram_din=8'h3C -> vram_addr=13'h0123 during the next CPU slot; cpu_ack=1 exactly one clock after its phase 3; cpu_rdata=8'h3C.
REQ-028 Write, cpu_addr=13'h1FFF, cpu_wdata=8'h5A -> vram_we high exactly 2 clocks (phases 1-2), vram_dout=8'h5A, vram_oe=0 throughout; one cpu_ack.
REQ-029 cpu_req held high for 3 CPU slots -> 3 acks spaced 8 clocks apart; video slots in between still give vid_valid.
REQ-030 Reset asserted at phase 1 of CPU_WR -> vram_we=0 on the next edge, no cpu_ack, first slot after release is VIDEO.
REQ-031 pq rise injected at phase 3 -> sync_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/k052109_pkg.sv
// Shared types and constants for the K052109 VRAM slot sequencer: slot states,
// default bus widths and the in-slot phase numbers.
package k052109_pkg;

    localparam int K_ADDR_W = 13;
    localparam int K_DATA_W = 8;

    localparam logic [1:0] WE_FIRST = 2'd1;
    localparam logic [1:0] WE_LAST  = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VIDEO  = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } slot_state_t;

endpackage

// File: rtl/k052109_phase_track.sv
// Tracks the E/Q timing phases: finds slot starts on pe rising edges, runs the
// 2-bit in-slot phase counter and flags Q edges that arrive out of place.
module k052109_phase_track
    import k052109_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pe,
    input  logic       pq,
    output logic       slot_start,
    output logic [1:0] phase,
    output logic       sync_err
);

    localparam logic [1:0] PQ_PHASE = 2'd1;

    logic       pe_q;
    logic       pq_q;
    logic       pq_rise;
    logic [1:0] phase_d;

    assign slot_start = pe & ~pe_q;
    assign pq_rise    = pq & ~pq_q;

    // Phase 3 holds until the next slot start instead of wrapping.
    always_comb begin
        phase_d = phase;
        if (slot_start) begin
            phase_d = 2'd0;
        end else if (phase != LATCH) begin
            phase_d = phase + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        pe_q <= pe;
        pq_q <= pq;
        if (reset) begin
            phase    <= 2'd0;
            sync_err <= 1'b0;
        end else begin
            phase <= phase_d;
            // A healthy Q edge lands on the clock that enters phase 1.
            if (pq_rise && (phase_d != PQ_PHASE)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/k052109_vram_slot_seq.sv
// VRAM slot sequencer: alternates video tile fetches and CPU accesses in
// four-phase slots, driving the VRAM bus and the CPU/video result strobes.
module k052109_vram_slot_seq
    import k052109_pkg::*;
#(
    parameter int ADDR_W = K_ADDR_W,
    parameter int DATA_W = K_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pe,
    input  logic              pq,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_din,
    output logic [DATA_W-1:0] vram_dout,
    output logic              vram_oe,
    output logic              vram_we,
    output logic              sync_err,
    output slot_state_t       dbg_state
);

    slot_state_t       state;
    slot_state_t       state_d;
    logic              slot_start;
    logic [1:0]        phase;
    logic              cpu_slot;
    logic              done;
    logic              latch_fire;
    logic [ADDR_W-1:0] cap_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] cap_wdata;

    k052109_phase_track u_phase_track (
        .clock      (clock),
        .reset      (reset),
        .pe         (pe),
        .pq         (pq),
        .slot_start (slot_start),
        .phase      (phase),
        .sync_err   (sync_err)
    );

    assign dbg_state = state;
    assign vram_dout = cap_wdata;

    always_comb begin
        state_d = state;
        if (slot_start) begin
            if (!cpu_slot) begin
                state_d = VIDEO;
            end else if (cpu_req) begin
                state_d = cpu_we ? CPU_WR : CPU_RD;
            end else begin
                state_d = IDLE;
            end
        end
        // done blocks a second latch/ack while phase 3 is stretched.
        latch_fire = (state != IDLE) && (phase == LATCH) && !done;
        vram_oe    = (state == VIDEO) || (state == CPU_RD);
        vram_we    = (state == CPU_WR) && (phase >= WE_FIRST) && (phase <= WE_LAST);
        case (state)
            VIDEO:          vram_addr = vid_addr;
            CPU_RD, CPU_WR: vram_addr = cap_addr;
            default:        vram_addr = last_addr;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cpu_slot  <= 1'b0;
            done      <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            last_addr <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
        end else begin
            state     <= state_d;
            last_addr <= vram_addr;
            vid_valid <= latch_fire && (state == VIDEO);
            cpu_ack   <= latch_fire && (state != VIDEO);
            if (latch_fire && (state == VIDEO)) begin
                vid_data <= vram_din;
            end
            if (latch_fire && (state == CPU_RD)) begin
                cpu_rdata <= vram_din;
            end
            if (slot_start) begin
                cpu_slot <= ~cpu_slot;
                done     <= 1'b0;
                if (cpu_slot && cpu_req) begin
                    cap_addr  <= cpu_addr;
                    cap_wdata <= cpu_wdata;
                end
            end else if (phase == LATCH) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_k052109_vram_slot_seq.sv
// Randomized bench for k052109_vram_slot_seq, checked every clock against a
// slot-level behavioural model of the sequencer.
module tb_k052109_vram_slot_seq;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    localparam int K_IDLE = 0;
    localparam int K_VID  = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;

    localparam int M_VID     = 0;
    localparam int M_RD      = 1;
    localparam int M_WR      = 2;
    localparam int M_RAND    = 3;
    localparam int M_STRETCH = 4;
    localparam int M_RST     = 5;
    localparam int M_WRRST   = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              pe;
    logic              pq;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_din;
    logic [DATA_W-1:0] vram_dout;
    logic              vram_oe;
    logic              vram_we;
    logic              sync_err;
    logic [1:0]        dbg_state;

    always #5 clock = ~clock;

    k052109_vram_slot_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .pe        (pe),
        .pq        (pq),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .vram_dout (vram_dout),
        .vram_oe   (vram_oe),
        .vram_we   (vram_we),
        .sync_err  (sync_err),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: one access kind per slot, timed by clocks since slot start.
    int                m_kind;
    int                m_since;
    bit                m_cpu_next;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [ADDR_W-1:0] m_last;
    logic [DATA_W-1:0] m_vdata;
    logic [DATA_W-1:0] m_rdata;
    bit                m_vvalid;
    bit                m_ack;
    bit                m_err;
    logic              prev_pe;
    logic              prev_pq;

    int gen_pos = 0;
    int gen_len = 4;
    bit wr_rst_done = 0;
    int dut_acks = 0, mdl_acks = 0, dut_vv = 0, mdl_vv = 0, dut_we = 0, mdl_we = 0;

    task automatic model_reset();
        m_kind     = K_IDLE;
        m_since    = 0;
        m_cpu_next = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_last     = '0;
        m_vdata    = '0;
        m_rdata    = '0;
        m_vvalid   = 0;
        m_ack      = 0;
        m_err      = 0;
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr();
        if (m_kind == K_VID) return vid_addr;
        if (m_kind == K_RD || m_kind == K_WR) return m_addr;
        return m_last;
    endfunction

    task automatic model_edge();
        logic [ADDR_W-1:0] cur_addr;
        bit start, pq_rise, fire;
        cur_addr = exp_addr();
        start    = pe && !prev_pe;
        pq_rise  = pq && !prev_pq;
        prev_pe  = pe;
        prev_pq  = pq;
        if (reset) begin
            model_reset();
            return;
        end
        fire     = (m_kind != K_IDLE) && (m_since == 3);
        m_vvalid = fire && (m_kind == K_VID);
        m_ack    = fire && (m_kind == K_RD || m_kind == K_WR);
        if (m_vvalid) m_vdata = vram_din;
        if (fire && m_kind == K_RD) m_rdata = vram_din;
        m_last = cur_addr;
        if (start) begin
            if (!m_cpu_next) begin
                m_kind = K_VID;
            end else if (cpu_req) begin
                m_kind  = cpu_we ? K_WR : K_RD;
                m_addr  = cpu_addr;
                m_wdata = cpu_wdata;
            end else begin
                m_kind = K_IDLE;
            end
            m_cpu_next = !m_cpu_next;
            m_since    = 0;
        end else if (m_since < 1000) begin
            m_since++;
        end
        if (pq_rise && m_since != 1) m_err = 1;
    endtask

    task automatic drive(input int mode);
        bit exp_we;
        gen_pos++;
        if (gen_pos >= gen_len) begin
            gen_pos = 0;
            gen_len = (mode == M_STRETCH && $urandom_range(0, 2) == 0) ? int'($urandom_range(5, 7)) : 4;
        end
        pq = pe;
        pe = (gen_pos < 2);
        if (mode == M_STRETCH && $urandom_range(0, 60) == 0) pq = ~pq;
        reset     = 1'b0;
        vid_addr  = ADDR_W'($urandom);
        cpu_addr  = ADDR_W'($urandom);
        cpu_wdata = DATA_W'($urandom);
        vram_din  = DATA_W'($urandom);
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        case (mode)
            M_VID: begin
                cpu_req  = 1'b0;
                vram_din = 8'hA5;
            end
            M_RD: begin
                cpu_req  = 1'b1;
                cpu_we   = 1'b0;
                cpu_addr = 13'h0123;
                vram_din = 8'h3C;
            end
            M_WR, M_WRRST: begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b1;
                cpu_addr  = 13'h1FFF;
                cpu_wdata = 8'h5A;
                exp_we    = (m_kind == K_WR) && (m_since == 1);
                if (mode == M_WRRST && exp_we && !wr_rst_done) begin
                    reset       = 1'b1;
                    wr_rst_done = 1;
                end
            end
            M_RST: reset = ($urandom_range(0, 39) == 0);
            default: ;
        endcase
    endtask

    task automatic compare_all();
        bit e_oe, e_we;
        e_oe = (m_kind == K_VID) || (m_kind == K_RD);
        e_we = (m_kind == K_WR) && (m_since == 1 || m_since == 2);
        check("vram_oe", 32'(vram_oe), 32'(e_oe));
        check("vram_we", 32'(vram_we), 32'(e_we));
        check("oe_we_excl", 32'(vram_oe & vram_we), 32'(0));
        check("vram_addr", 32'(vram_addr), 32'(exp_addr()));
        check("vram_dout", 32'(vram_dout), 32'(m_wdata));
        check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
        check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        check("vid_valid", 32'(vid_valid), 32'(m_vvalid));
        check("vid_data", 32'(vid_data), 32'(m_vdata));
        check("sync_err", 32'(sync_err), 32'(m_err));
        dut_acks += int'(cpu_ack);
        mdl_acks += int'(m_ack);
        dut_vv   += int'(vid_valid);
        mdl_vv   += int'(m_vvalid);
        dut_we   += int'(vram_we);
        mdl_we   += int'(e_we);
    endtask

    task automatic step(input int mode);
        @(negedge clock);
        drive(mode);
        #1;
        compare_all();
        @(posedge clock);
        model_edge();
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) step(mode);
    endtask

    initial begin
        reset     = 1'b1;
        pe        = 1'b0;
        pq        = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        vid_addr  = '0;
        vram_din  = '0;
        repeat (2) @(posedge clock);
        model_reset();
        prev_pe = pe;
        prev_pq = pq;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            compare_all();
            @(posedge clock);
            model_edge();
        end
        reset = 1'b0;
        run(M_VID, 40);
        run(M_RD, 32);
        run(M_WR, 24);
        run(M_RAND, 300);
        run(M_WRRST, 40);
        run(M_VID, 20);
        run(M_STRETCH, 400);
        run(M_RST, 400);
        run(M_RAND, 60);
        check("ack_total", 32'(dut_acks), 32'(mdl_acks));
        check("vvalid_total", 32'(dut_vv), 32'(mdl_vv));
        check("we_cycles_total", 32'(dut_we), 32'(mdl_we));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
